// File: rtl/disp_demux.sv
// disp_demux: captures each digit of a multiplexed active-low 7-seg bus once {an,sseg} has been stable for STABLE_CNT cycles.
module disp_demux #(
    parameter int STABLE_CNT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    input  logic       clr_err,
    output logic [7:0] d0,
    output logic [7:0] d1,
    output logic [7:0] d2,
    output logic [7:0] d3,
    output logic [3:0] seen,
    output logic       frame_tick,
    output logic       err
);
    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CNT);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CNT - 1);
    logic [11:0]     s1, s2, p;
    logic [7:0]      cnt;
    logic [3:0][7:0] d;
    logic [3:0]      sel, seen_acc;
    logic            ev, one_hot, multi;
    always_comb begin
        sel      = ~s2[11:8];
        ev       = (cnt == CNT_LAST) && (s2 == p);
        one_hot  = $onehot(sel);
        multi    = !one_hot && (sel != 4'h0);
        seen_acc = seen | sel;
    end
    // seen wraps to zero on the same edge that completes the frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1         <= '1;
            s2         <= '1;
            p          <= '1;
            cnt        <= '0;
            d          <= '1;
            seen       <= '0;
            frame_tick <= 1'b0;
            err        <= 1'b0;
        end else begin
            s1         <= {an, sseg};
            s2         <= s1;
            p          <= s2;
            cnt        <= (s2 != p) ? 8'd0 : (cnt < CNT_MAX) ? cnt + 8'd1 : cnt;
            frame_tick <= ev && one_hot && (seen_acc == 4'hF);
            err        <= (ev && multi) ? 1'b1 : clr_err ? 1'b0 : err;
            if (ev && one_hot) begin
                seen <= (seen_acc == 4'hF) ? 4'h0 : seen_acc;
                for (int i = 0; i < 4; i++)
                    if (sel[i]) d[i] <= s2[7:0];
            end
        end
    end
    assign d0 = d[0];
    assign d1 = d[1];
    assign d2 = d[2];
    assign d3 = d[3];
endmodule

// File: tb/tb_disp_demux.sv
// tb_disp_demux: randomized + directed scoreboard bench for disp_demux against a run-length reference model.
module tb_disp_demux;
    localparam int S = 4;
    logic       clk = 0, reset_n = 0, clr_err = 0;
    logic [3:0] an = 4'hF;
    logic [7:0] sseg = 8'hFF;
    logic [7:0] d0, d1, d2, d3;
    logic [3:0] seen;
    logic       frame_tick, err;
    int compared = 0, mismatched = 0;

    typedef struct packed {
        logic [3:0][7:0] d;
        logic [3:0]      seen;
        logic            tick;
        logic            err;
    } exp_t;
    exp_t q[$];

    disp_demux #(.STABLE_CNT(S)) dut (
        .clk(clk), .reset_n(reset_n), .an(an), .sseg(sseg), .clr_err(clr_err),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .seen(seen),
        .frame_tick(frame_tick), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: a capture fires when the input value seen two edges late has
    // been constant for exactly S+1 consecutive edge samples.
    initial begin
        exp_t m;
        logic [11:0] h0, h1, v, last;
        int run, nz, idx;
        m = '{d: '1, seen: 4'h0, tick: 1'b0, err: 1'b0};
        h0 = '1; h1 = '1; last = '1; run = 1;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m = '{d: '1, seen: 4'h0, tick: 1'b0, err: 1'b0};
                h0 = '1; h1 = '1; last = '1; run = 1;
            end else begin
                v = h1; h1 = h0; h0 = {an, sseg};
                run = (v == last) ? ((run < 1000) ? run + 1 : run) : 1;
                last = v;
                m.tick = 1'b0;
                nz = 4 - $countones(v[11:8]);
                if (clr_err) m.err = 1'b0;
                if (run == S + 1) begin
                    if (nz == 1) begin
                        idx = 0;
                        for (int i = 0; i < 4; i++) if (!v[8+i]) idx = i;
                        m.d[idx] = v[7:0];
                        m.seen[idx] = 1'b1;
                        if (m.seen == 4'hF) begin
                            m.tick = 1'b1;
                            m.seen = 4'h0;
                        end
                    end else if (nz >= 2) m.err = 1'b1;
                end
            end
            q.push_back(m);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("d0", 32'(d0), 32'(e.d[0]));
                chk("d1", 32'(d1), 32'(e.d[1]));
                chk("d2", 32'(d2), 32'(e.d[2]));
                chk("d3", 32'(d3), 32'(e.d[3]));
                chk("seen", 32'(seen), 32'(e.seen));
                chk("frame_tick", 32'(frame_tick), 32'(e.tick));
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n, input logic c = 1'b0);
        an = a; sseg = s; clr_err = c;
        @(negedge clk);
        clr_err = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan();
        hold(4'b1110, 8'hC0, 10);
        hold(4'b1101, 8'hF9, 10);
        hold(4'b1011, 8'hA4, 10);
        hold(4'b0111, 8'hB0, 10);
    endtask

    initial begin
        logic [3:0] a;
        repeat (3) @(negedge clk);
        reset_n = 1;
        hold(4'b1110, 8'hC0, 10);
        scan();
        hold(4'b1101, 8'hF9, 10);
        hold(4'b1101, 8'h00, 2);
        hold(4'b1101, 8'hF9, 10);
        hold(4'b1100, 8'h55, 10);
        hold(4'b1100, 8'h55, 3, 1'b1);
        hold(4'b1110, 8'hC0, 10);
        hold(4'b1101, 8'hF9, 10);
        hold(4'b1011, 8'hA4, 3);
        #1 reset_n = 0;
        #1;
        chk("rst_d0", 32'(d0), 32'hFF);
        chk("rst_d1", 32'(d1), 32'hFF);
        chk("rst_d2", 32'(d2), 32'hFF);
        chk("rst_d3", 32'(d3), 32'hFF);
        chk("rst_seen", 32'(seen), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        hold(4'b1011, 8'hA4, 10);
        scan();
        hold(4'b1111, 8'h12, 20);
        repeat (250) begin
            case ($urandom_range(0, 9))
                7: a = 4'hF;
                8: a = 4'(~((1 << $urandom_range(0, 3)) | (1 << $urandom_range(0, 3)) | 4'b0101));
                9: a = 4'($urandom);
                default: a = 4'(~(1 << $urandom_range(0, 3)));
            endcase
            hold(a, 8'($urandom), $urandom_range(1, 10), $urandom_range(0, 7) == 0);
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
